// File: rtl/nbr_mem_arbiter_pkg.sv
// Shared definitions for the neighbour/knownCH table arbiter: table geometry,
// requester indices, arbiter state encoding and a width helper.
package nbr_mem_arbiter_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int WORD_WIDTH = 16;
    localparam int TBL_ADDR_W = 11;

    localparam int REQ_QTUPD  = 0;
    localparam int REQ_HOPSEL = 1;
    localparam int REQ_TXPKT  = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } arb_state_e;

    // Index width for n items, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nbr_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching from
// ptr_i upward, wrapping modulo N. Shared with other arbiters.
module nbr_mem_arbiter_rr_pick
    import nbr_mem_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = clog2_min1(N)
)(
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest one wins
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % N);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/nbr_mem_arbiter.sv
// Round-robin arbiter in front of the single-port neighbour table SRAM.
// The owner keeps the port while req or lock is high; a watchdog revokes it
// after MAX_HOLD cycles. One idle cycle always separates two owners so the
// last read's rvalid lands before anyone else is granted.
module nbr_mem_arbiter
    import nbr_mem_arbiter_pkg::*;
#(
    parameter int  NUM_REQ  = 3,
    parameter int  ADDR_W   = TBL_ADDR_W,
    parameter int  DATA_W   = WORD_WIDTH,
    parameter int  MAX_HOLD = 64,
    localparam int OWN_W    = clog2_min1(NUM_REQ)
)(
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [OWN_W-1:0]          owner_id_o,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int                HCNT_W    = clog2_min1(MAX_HOLD);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);
    localparam logic [OWN_W-1:0]  LAST_IDX  = OWN_W'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    ptr_q, ptr_d;
    logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                timeout_q, timeout_d;

    logic                pick_found;
    logic [OWN_W-1:0]    pick_idx;
    logic                acc;

    nbr_mem_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (OWN_W)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Owner access strobe; non-owner requests never reach the SRAM
    assign acc = (state_q == S_OWN) && req_i[owner_q] && gnt_q[owner_q];

    // Drive the SRAM from the owner's slice during an access, idle otherwise
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (acc) begin
            mem_en_o    = 1'b1;
            mem_we_o    = req_wr_i[owner_q];
            mem_addr_o  = req_addr_i[owner_q*ADDR_W +: ADDR_W];
            mem_wdata_o = req_wdata_i[owner_q*DATA_W +: DATA_W];
        end
    end

    // Next-state: arbitration, release, watchdog revoke and read-valid pipeline
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        rvalid_d   = '0;

        if (acc && !req_wr_i[owner_q]) begin
            rvalid_d[owner_q] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    ptr_d           = (pick_idx == LAST_IDX) ? '0 : pick_idx + OWN_W'(1);
                    hold_cnt_d      = '0;
                    state_d         = S_OWN;
                end
            end
            S_OWN: begin
                if (!req_i[owner_q] && !lock_i[owner_q]) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Counter stays at the compare value; it is cleared on the next grant
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = mem_rdata_i;
    assign owner_id_o = owner_q;
    assign busy_o     = (state_q == S_OWN);
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_nbr_mem_arbiter.sv
// Directed bench for nbr_mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_nbr_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic [2:0]  req, lock, req_wr;
    logic [32:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [1:0]  owner_id;
    logic        busy, timeout;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wcnt, cnt, tocnt;
    bit got0;

    logic [15:0] mem [2048];
    bit          written [2048];

    always #5 clk = ~clk;

    nbr_mem_arbiter dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_i       (req),
        .lock_i      (lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wr_i    (req_wr),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .owner_id_o  (owner_id),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    function automatic logic [15:0] init_val(input int a);
        if (a >= 32'h20 && a <= 32'h22) return 16'(16'h5A00 + a - 32'h20);
        if (a == 32'h100) return 16'h1234;
        return 16'h0000;
    endfunction

    function automatic logic [15:0] peek(input int a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    // SRAM model: registered read, counted writes
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
                wr_cnt            <= wr_cnt + 1;
            end else begin
                mem_rdata <= peek(int'(mem_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int i, input int a, input int d, input logic w);
        req_addr[i*11 +: 11]  = 11'(a);
        req_wdata[i*16 +: 16] = 16'(d);
        req_wr[i]             = w;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int exp;
        nrst      = 1'b0;
        req       = 3'b111;
        lock      = 3'b000;
        req_wr    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 3; i++) set_slot(i, 32'h20 + i, 0, 1'b0);

        // Reset with all requests high
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_owner", 32'(owner_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        nrst = 1'b1;
        @(negedge clk);

        // Round-robin single-word reads: 0,1,2,0,1,2,0
        for (int k = 0; k < 7; k++) begin
            exp = k % 3;
            #1;
            chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(1) << exp);
            chk($sformatf("rr%0d_owner", k), 32'(owner_id), 32'(exp));
            chk($sformatf("rr%0d_mem_en", k), 32'(mem_en), 1);
            chk($sformatf("rr%0d_busy", k), 32'(busy), 1);
            @(negedge clk);
            req[exp] = 1'b0;
            #1;
            chk($sformatf("rr%0d_rvalid", k), 32'(rvalid), 32'(1) << exp);
            chk($sformatf("rr%0d_rdata", k), 32'(rdata), 32'h5A00 + 32'(exp));
            chk($sformatf("rr%0d_rel_mem_en", k), 32'(mem_en), 0);
            @(negedge clk);
            req = (k == 6) ? 3'b011 : 3'b111;
            #1;
            chk($sformatf("rr%0d_idle_gnt", k), 32'(gnt), 0);
            chk($sformatf("rr%0d_idle_busy", k), 32'(busy), 0);
            @(negedge clk);
        end

        // Locked burst by requester 1 while requester 0 waits
        #1;
        chk("burst_gnt", 32'(gnt), 32'b010);
        lock[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_slot(1, 32'h10 + j, 32'hA0 + j, 1'b1);
            #1;
            chk($sformatf("bw%0d_we", j), 32'(mem_we), 1);
            chk($sformatf("bw%0d_addr", j), 32'(mem_addr), 32'h10 + 32'(j));
            chk($sformatf("bw%0d_wdata", j), 32'(mem_wdata), 32'hA0 + 32'(j));
            chk($sformatf("bw%0d_gnt", j), 32'(gnt), 32'b010);
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            set_slot(1, 32'h10 + j, 0, 1'b0);
            #1;
            chk($sformatf("br%0d_we", j), 32'(mem_we), 0);
            chk($sformatf("br%0d_rvalid", j), 32'(rvalid), (j == 0) ? 32'b000 : 32'b010);
            if (j > 0) chk($sformatf("br%0d_rdata", j), 32'(rdata), 32'hA0 + 32'(j) - 1);
            chk($sformatf("br%0d_gnt", j), 32'(gnt), 32'b010);
            @(negedge clk);
        end
        req[1] = 1'b0;
        #1;
        chk("br_last_rvalid", 32'(rvalid), 32'b010);
        chk("br_last_rdata", 32'(rdata), 32'hA3);
        chk("lock_hold_mem_en", 32'(mem_en), 0);
        @(negedge clk);
        #1;
        chk("lock_hold_gnt", 32'(gnt), 32'b010);
        chk("lock_hold_rvalid", 32'(rvalid), 0);
        lock[1] = 1'b0;
        @(negedge clk);
        #1;
        chk("unlock_idle_gnt", 32'(gnt), 0);
        @(negedge clk);
        #1;
        chk("after_lock_gnt0", 32'(gnt), 32'b001);

        // Non-owner write to the same address must not reach the SRAM
        wcnt = wr_cnt;
        set_slot(0, 32'h100, 0, 1'b0);
        set_slot(1, 32'h100, 32'hFFFF, 1'b1);
        req = 3'b011;
        #1;
        chk("iso_mem_en", 32'(mem_en), 1);
        chk("iso_mem_we", 32'(mem_we), 0);
        chk("iso_mem_addr", 32'(mem_addr), 32'h100);
        chk("iso_owner", 32'(owner_id), 0);
        @(negedge clk);
        req = 3'b000;
        #1;
        chk("iso_rvalid", 32'(rvalid), 32'b001);
        chk("iso_rdata", 32'(rdata), 32'h1234);
        @(negedge clk);
        #1;
        chk("iso_idle_gnt", 32'(gnt), 0);
        chk("iso_mem_kept", 32'(peek(32'h100)), 32'h1234);
        chk("iso_wr_cnt", 32'(wr_cnt), 32'(wcnt));

        // Watchdog: requester 2 holds req+lock forever, requester 0 pending
        set_slot(0, 32'h20, 0, 1'b0);
        set_slot(1, 32'h20, 0, 1'b0);
        set_slot(2, 32'h22, 0, 1'b0);
        req  = 3'b101;
        lock = 3'b100;
        @(negedge clk);
        cnt   = 0;
        tocnt = 0;
        got0  = 1'b0;
        for (int i = 0; i < 90 && !got0; i++) begin
            #1;
            if (gnt == 3'b100) cnt++;
            if (timeout === 1'b1) begin
                tocnt++;
                chk("wd_last_rvalid", 32'(rvalid), 32'b100);
            end
            if (gnt == 3'b001) got0 = 1'b1;
            else @(negedge clk);
        end
        chk("wd_hold_cycles", 32'(cnt), 64);
        chk("wd_timeouts", 32'(tocnt), 1);
        chk("wd_next_gnt", 32'(gnt), 32'b001);

        // Reset in the cycle of a pending read: rvalid dropped, no write afterwards
        req  = 3'b001;
        lock = 3'b001;
        set_slot(0, 32'h20, 0, 1'b0);
        #1;
        chk("mrst_mem_en", 32'(mem_en), 1);
        @(negedge clk);
        #1;
        chk("mrst_rvalid_pre", 32'(rvalid), 32'b001);
        chk("mrst_rdata_pre", 32'(rdata), 32'h5A00);
        set_slot(0, 32'h21, 0, 1'b0);
        nrst = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_rvalid", 32'(rvalid), 0);
        chk("mrst_gnt", 32'(gnt), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_owner", 32'(owner_id), 0);
        wcnt = wr_cnt;
        set_slot(0, 32'h21, 32'hBEEF, 1'b1);
        #1;
        chk("mrst_mem_en_off", 32'(mem_en), 0);
        chk("mrst_mem_we_off", 32'(mem_we), 0);
        @(negedge clk);
        #1;
        chk("mrst_wr_cnt", 32'(wr_cnt), 32'(wcnt));
        chk("mrst_mem_kept", 32'(peek(32'h21)), 32'h5A01);
        nrst = 1'b1;
        req  = 3'b000;
        lock = 3'b000;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
